// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS generator/checker pair.
//   - State encoding of the checker FSM.
//   - Default LFSR length, feedback mask and seed, so both ends of the
//     link are built from the same constants.
package prbs_pkg;

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  typedef enum logic [1:0] {
    ST_FILL   = FILL,
    ST_VERIFY = VERIFY,
    ST_LOCKED = LOCKED
  } prbs_state_e;

  localparam int                   DEF_WIDTH = 10;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS  = 10'h2C2;
  localparam logic [DEF_WIDTH-1:0] DEF_SEED  = 10'h2AA;

endpackage

// File: rtl/prbs_predict.sv
// prbs_predict: next-bit predictor of a Fibonacci LFSR.
//   lfsr     in   WIDTH  current LFSR state
//   taps     in   WIDTH  feedback mask
//   expected out  1      parity of the tapped bits (the next stream bit)
// Purely combinational; shared by the generator and the checker.
module prbs_predict
  import prbs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] lfsr,
  input  logic [WIDTH-1:0] taps,
  output logic             expected
);

  assign expected = ^(lfsr & taps);

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: locks onto a serial Fibonacci-LFSR stream and counts bit
// errors once locked.
//   clk_i        in   1      clock, rising edge
//   rst_ni       in   1      synchronous active-low reset
//   bit_i        in   1      received stream bit
//   valid_i      in   1      bit_i carries a new stream bit this cycle
//   clear_i      in   1      synchronous clear of err_count_o
//   locked_o     out  1      checker is locked
//   err_pulse_o  out  1      one-cycle pulse per mismatching bit while locked
//   err_count_o  out  ERR_W  saturating mismatch count while locked
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS        = DEF_TAPS,
  parameter int               LOCK_COUNT  = 16,
  parameter int               WINDOW      = 256,
  parameter int               UNLOCK_ERRS = 4,
  parameter int               ERR_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             bit_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_count_o
);

  localparam int FILL_W  = $clog2(WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  WERR_LAST  = WERR_W'(UNLOCK_ERRS - 1);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  prbs_state_e        state_p0, state_nxt;
  logic [WIDTH-1:0]   lfsr_p0, lfsr_nxt;
  logic [FILL_W-1:0]  fill_cnt_p0, fill_cnt_nxt;
  logic [MATCH_W-1:0] match_cnt_p0, match_cnt_nxt;
  logic [WIN_W-1:0]   win_cnt_p0, win_cnt_nxt;
  logic [WERR_W-1:0]  win_errs_p0, win_errs_nxt;
  logic               locked_p1, locked_nxt;
  logic               err_pulse_p1, err_pulse_nxt;
  logic [ERR_W-1:0]   err_cnt_p1, err_cnt_nxt;
  logic               expected;
  logic               mismatch;

  prbs_predict #(.WIDTH(WIDTH)) u_predict (
    .lfsr     (lfsr_p0),
    .taps     (TAPS),
    .expected (expected)
  );

  // Stage p0 -> p1: next-state, predictor and counter update
  always_comb begin
    state_nxt     = state_p0;
    lfsr_nxt      = lfsr_p0;
    fill_cnt_nxt  = fill_cnt_p0;
    match_cnt_nxt = match_cnt_p0;
    win_cnt_nxt   = win_cnt_p0;
    win_errs_nxt  = win_errs_p0;
    err_pulse_nxt = 1'b0;
    err_cnt_nxt   = err_cnt_p1;
    mismatch      = 1'b0;

    if (valid_i) begin
      unique case (state_p0)
        ST_FILL: begin
          lfsr_nxt     = {lfsr_p0[WIDTH-2:0], bit_i};
          fill_cnt_nxt = fill_cnt_p0 + 1'b1;
          if (fill_cnt_p0 == FILL_LAST) begin
            state_nxt     = ST_VERIFY;
            match_cnt_nxt = '0;
          end
        end
        ST_VERIFY: begin
          // Loading the received bit lets the predictor resynchronise on
          // its own; an all-zero register never counts as a match so a
          // stuck-low line cannot lock.
          lfsr_nxt = {lfsr_p0[WIDTH-2:0], bit_i};
          if ((bit_i == expected) && (lfsr_p0 != '0)) begin
            match_cnt_nxt = match_cnt_p0 + 1'b1;
            if (match_cnt_p0 == MATCH_LAST) begin
              state_nxt    = ST_LOCKED;
              win_cnt_nxt  = '0;
              win_errs_nxt = '0;
            end
          end else begin
            match_cnt_nxt = '0;
          end
        end
        ST_LOCKED: begin
          // Free-running predictor: a single line error is one mismatch.
          lfsr_nxt      = {lfsr_p0[WIDTH-2:0], expected};
          mismatch      = (bit_i != expected);
          err_pulse_nxt = mismatch;
          if (mismatch) win_errs_nxt = win_errs_p0 + 1'b1;
          if (win_cnt_p0 == WIN_LAST) begin
            win_cnt_nxt  = '0;
            win_errs_nxt = '0;
          end else begin
            win_cnt_nxt = win_cnt_p0 + 1'b1;
          end
          // Unlock takes priority over a window completing this bit.
          if (mismatch && (win_errs_p0 == WERR_LAST)) begin
            state_nxt    = ST_FILL;
            fill_cnt_nxt = '0;
          end
        end
        default: state_nxt = ST_FILL;
      endcase
    end

    if (clear_i) begin
      err_cnt_nxt = mismatch ? ERR_W'(1) : '0;
    end else if (mismatch) begin
      err_cnt_nxt = sat_inc(err_cnt_p1);
    end
  end

  assign locked_nxt = (state_nxt == ST_LOCKED);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_p0     <= ST_FILL;
      lfsr_p0      <= '0;
      fill_cnt_p0  <= '0;
      match_cnt_p0 <= '0;
      win_cnt_p0   <= '0;
      win_errs_p0  <= '0;
      locked_p1    <= 1'b0;
      err_pulse_p1 <= 1'b0;
      err_cnt_p1   <= '0;
    end else begin
      state_p0     <= state_nxt;
      lfsr_p0      <= lfsr_nxt;
      fill_cnt_p0  <= fill_cnt_nxt;
      match_cnt_p0 <= match_cnt_nxt;
      win_cnt_p0   <= win_cnt_nxt;
      win_errs_p0  <= win_errs_nxt;
      locked_p1    <= locked_nxt;
      err_pulse_p1 <= err_pulse_nxt;
      err_cnt_p1   <= err_cnt_nxt;
    end
  end

  assign locked_o    = locked_p1;
  assign err_pulse_o = err_pulse_p1;
  assign err_count_o = err_cnt_p1;

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker: a reference generator drives the stream,
// expected err_pulse_o values are queued as bits are driven and compared
// when the DUT responds one edge later.
module tb_prbs_checker;
  import prbs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        bit_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        locked_o, err_pulse_o;
  logic [15:0] err_count_o;
  logic        locked2, pulse2;
  logic [3:0]  cnt2;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic [9:0] gen;
  int since_lock;

  always #5 clk = ~clk;

  prbs_checker #(.WIDTH(10), .TAPS(10'h2C2), .LOCK_COUNT(16), .WINDOW(256),
                 .UNLOCK_ERRS(4), .ERR_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bit_i(bit_i), .valid_i(valid_i), .clear_i(clear_i),
    .locked_o(locked_o), .err_pulse_o(err_pulse_o), .err_count_o(err_count_o));

  // Second instance: narrow counter, unlock threshold equal to the window.
  prbs_checker #(.WIDTH(10), .TAPS(10'h2C2), .LOCK_COUNT(16), .WINDOW(256),
                 .UNLOCK_ERRS(256), .ERR_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_ni), .bit_i(bit_i), .valid_i(valid_i), .clear_i(clear_i),
    .locked_o(locked2), .err_pulse_o(pulse2), .err_count_o(cnt2));

  // Drive one cycle; exp_pulse < 0 means main-DUT pulse is not scored.
  task automatic step(input logic v, input logic b, input logic clr, input int exp_pulse);
    int e;
    valid_i = v; bit_i = b; clear_i = clr;
    if (exp_pulse >= 0) exp_q.push_back(exp_pulse);
    @(posedge clk); #1;
    if (exp_pulse >= 0) begin
      e = exp_q.pop_front();
      checks++;
      if (err_pulse_o !== e[0]) begin
        errors++;
        $display("FAIL err_pulse @%0t: got %b expected %b", $time, err_pulse_o, e[0]);
      end
    end
    valid_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic gen_bit(output logic b);
    b = ^(gen & 10'h2C2);
    gen = {gen[8:0], b};
  endtask

  task automatic send(input logic flip, input int exp_pulse);
    logic b;
    gen_bit(b);
    step(1'b1, b ^ flip, 1'b0, exp_pulse);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0; valid_i = 1'b0; clear_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_i = 1'($urandom); valid_i = 1'b1; clear_i = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    checks++; if (err_pulse_o !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", err_pulse_o); end
    checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", err_count_o); end
    rst_ni = 1'b1; valid_i = 1'b0; clear_i = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'($urandom), 1'b0, 0);
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL idle_locked: got %b want 0", locked_o); end
    checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL idle_count: got %0d want 0", err_count_o); end
  endtask

  task automatic test_lock();
    gen = DEF_SEED;
    for (int i = 1; i <= 26; i++) begin
      send(1'b0, 0);
      if (i == 25) begin
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", locked_o); end
      end
    end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL lock_at_26: got %b want 1", locked_o); end
    since_lock = 0;
    for (int i = 0; i < 4092; i++) begin send(1'b0, 0); since_lock++; end
    checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL clean_count: got %0d want 0", err_count_o); end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL clean_locked: got %b want 1", locked_o); end
  endtask

  task automatic test_single_err();
    send(1'b1, 1); since_lock++;
    step(1'b0, 1'b0, 1'b0, 0);
    checks++; if (err_count_o !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", err_count_o); end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL single_locked: got %b want 1", locked_o); end
    for (int i = 0; i < 10; i++) begin send(1'b0, 0); since_lock++; end
  endtask

  task automatic test_unlock();
    step(1'b0, 1'b0, 1'b1, 0);
    checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL clear_idle: got %0d want 0", err_count_o); end
    while ((since_lock % 256) != 0) begin send(1'b0, 0); since_lock++; end
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 1); since_lock++;
      if (k < 3) begin
        checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL unlock_early k=%0d: got %b want 1", k, locked_o); end
        for (int j = 0; j < 4; j++) begin send(1'b0, 0); since_lock++; end
      end
    end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL unlock_fall: got %b want 0", locked_o); end
    checks++; if (err_count_o !== 16'd4) begin errors++; $display("FAIL unlock_count: got %0d want 4", err_count_o); end
    for (int i = 1; i <= 26; i++) begin
      send(1'b0, 0);
      if (i == 25) begin
        checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked_o); end
      end
    end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked_o); end
    since_lock = 0;
    for (int w = 0; w < 2; w++) begin
      for (int j = 0; j < 256; j++) begin
        logic f;
        f = (j == 0 || j == 50 || j == 100);
        send(f, int'(f)); since_lock++;
      end
      checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL three_errs w=%0d: got %b want 1", w, locked_o); end
    end
    checks++; if (err_count_o !== 16'd10) begin errors++; $display("FAIL three_errs_count: got %0d want 10", err_count_o); end
  endtask

  task automatic test_no_lock_zero();
    logic ever;
    do_reset();
    ever = 1'b0;
    for (int i = 0; i < 500; i++) begin step(1'b1, 1'b0, 1'b0, 0); ever |= locked_o; end
    for (int i = 0; i < 500; i++) begin step(1'b1, 1'b1, 1'b0, 0); ever |= locked_o; end
    checks++; if (ever !== 1'b0) begin errors++; $display("FAIL stuck_lock: got %b want 0", ever); end
  endtask

  task automatic test_gaps();
    int nvalid, cycles;
    logic b;
    do_reset();
    gen = DEF_SEED; nvalid = 0; cycles = 0;
    while (nvalid < 30 && cycles < 2000) begin
      if ($urandom_range(0, 1) == 1) begin
        gen_bit(b); step(1'b1, b, 1'b0, 0); nvalid++;
      end else begin
        step(1'b0, 1'($urandom), 1'b0, 0);
      end
      cycles++;
      checks++;
      if (locked_o !== (nvalid >= 26)) begin
        errors++; $display("FAIL gap_lock nvalid=%0d: got %b want %b", nvalid, locked_o, nvalid >= 26);
      end
    end
    checks++; if (nvalid < 30) begin errors++; $display("FAIL gap_budget: got %0d want 30", nvalid); end
  endtask

  task automatic test_clear();
    logic b;
    for (int i = 0; i < 5; i++) send(1'b0, 0);
    gen_bit(b);
    step(1'b1, ~b, 1'b1, 1);
    checks++; if (err_count_o !== 16'd1) begin errors++; $display("FAIL clear_err: got %0d want 1", err_count_o); end
    step(1'b0, 1'b0, 1'b1, 0);
    checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL clear_noerr: got %0d want 0", err_count_o); end
  endtask

  task automatic test_saturate();
    int want;
    do_reset();
    gen = DEF_SEED;
    for (int i = 0; i < 26; i++) send(1'b0, -1);
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_lock: got %b want 1", locked2); end
    for (int i = 0; i < 20; i++) begin
      send(1'b1, -1);
      want = (i + 1 > 15) ? 15 : i + 1;
      checks++; if (pulse2 !== 1'b1) begin errors++; $display("FAIL sat_pulse i=%0d: got %b want 1", i, pulse2); end
      checks++; if (cnt2 !== 4'(want)) begin errors++; $display("FAIL sat_count i=%0d: got %0d want %0d", i, cnt2, want); end
      send(1'b0, -1);
    end
    checks++; if (locked2 !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", locked2); end
  endtask

  task automatic test_reset_mid();
    logic b;
    do_reset();
    gen = DEF_SEED;
    for (int i = 0; i < 26; i++) send(1'b0, 0);
    send(1'b1, 1);
    checks++; if (err_count_o !== 16'd1) begin errors++; $display("FAIL mid_pre_count: got %0d want 1", err_count_o); end
    gen_bit(b);
    rst_ni = 1'b0; valid_i = 1'b1; bit_i = ~b; clear_i = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1; valid_i = 1'b0;
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL mid_locked: got %b want 0", locked_o); end
    checks++; if (err_pulse_o !== 1'b0) begin errors++; $display("FAIL mid_pulse: got %b want 0", err_pulse_o); end
    checks++; if (err_count_o !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", err_count_o); end
    checks++; if (cnt2 !== 4'd0) begin errors++; $display("FAIL mid_count2: got %0d want 0", cnt2); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_lock();
    test_single_err();
    test_unlock();
    test_no_lock_zero();
    test_gaps();
    test_clear();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
